// File: rtl/axil_bar_master.sv
// AXI4-Lite master translating BAR-relative word requests into AXI byte-address transactions.
// Optional build macro AXIL_BAR_MASTER_TIMEOUT_EN adds per-channel timeouts, FLUSH states and timeout_err.
module axil_bar_master #(
  parameter int           DATA_W      = 32,
  parameter int           NUM_BARS    = 4,
  parameter logic [127:0] BAR_ADDR    = {32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000},
  parameter logic [127:0] BAR_MASK    = {4{32'hFFFF8000}},
  parameter int           TIMEOUT_CYC = 1024
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [31:0]           rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_data_valid,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [31:0]           wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  output logic                  wr_done,
  output logic [1:0]            wr_resp,
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic [1:0]            wr_state_dbg,
  output logic [1:0]            rd_state_dbg,
  output logic [31:0]           M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [31:0]           M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);
  // Handshake rule: a transfer happens on the rising edge where VALID && READY are both high;
  // VALID never depends on READY and is held until that edge.
  localparam int         STRB_W = DATA_W / 8;
  localparam int         LSB    = $clog2(STRB_W);
  localparam logic [2:0] NB     = 3'(NUM_BARS);

  typedef enum logic [1:0] {
    W_IDLE, W_AW_W, W_B
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    , W_FLUSH
`endif
  } wr_state_t;
  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_R
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    , R_FLUSH
`endif
  } rd_state_t;

  function automatic logic [31:0] xlate(input logic [31:0] a);
    logic [31:0] b;
    logic [6:0]  base;
    base = {a[31:30], 5'b00000};
    b    = {2'b00, a[29:0]} << LSB;
    return (b & ~BAR_MASK[base +: 32]) | BAR_ADDR[base +: 32];
  endfunction

  wr_state_t           wr_state_q, wr_state_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [31:0]         awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wr_done_q, wr_done_d, rd_valid_q, rd_valid_d;
  logic [1:0]          wr_resp_q, wr_resp_d, rd_resp_q, rd_resp_d;

  assign wr_req_ready  = (wr_state_q == W_IDLE) && M_AXI_ARESETN;
  assign rd_req_ready  = (rd_state_q == R_IDLE) && M_AXI_ARESETN;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b001;
  assign M_AXI_ARVALID = arvalid_q;
  assign wr_done       = wr_done_q;
  assign wr_resp       = wr_resp_q;
  assign rd_data       = rd_data_q;
  assign rd_resp       = rd_resp_q;
  assign rd_data_valid = rd_valid_q;
  assign wr_state_dbg  = wr_state_q;
  assign rd_state_dbg  = rd_state_q;

`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             wr_to, rd_to, to_err_q;
  assign timeout_err  = to_err_q;
  // During a flush the response channel opens only after the address/data beats have gone out.
  assign M_AXI_BREADY = (wr_state_q == W_B) || (wr_state_q == W_FLUSH && !awvalid_q && !wvalid_q);
  assign M_AXI_RREADY = (rd_state_q == R_R) || (rd_state_q == R_FLUSH && !arvalid_q);
`else
  assign M_AXI_BREADY = (wr_state_q == W_B);
  assign M_AXI_RREADY = (rd_state_q == R_R);
`endif

  always_comb begin
    wr_state_d = wr_state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_done_d  = 1'b0;
    wr_resp_d  = wr_resp_q;
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    wcnt_d = wcnt_q + 1'b1;
    wr_to  = 1'b0;
`endif
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req_valid && wr_req_ready) begin
          if ({1'b0, wr_addr[31:30]} >= NB) begin
            wr_done_d = 1'b1;
            wr_resp_d = 2'b11;
          end else begin
            wr_state_d = W_AW_W;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            awaddr_d   = xlate(wr_addr);
            wdata_d    = wr_data;
            wstrb_d    = wr_be;
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
            wcnt_d = '0;
`endif
          end
        end
      end
      W_AW_W: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) wr_state_d = W_B;
      end
      W_B: begin
        if (M_AXI_BVALID) begin
          wr_state_d = W_IDLE;
          wr_done_d  = 1'b1;
          wr_resp_d  = M_AXI_BRESP;
        end
      end
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
      W_FLUSH: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (M_AXI_BREADY && M_AXI_BVALID) wr_state_d = W_IDLE;
      end
`endif
      default: wr_state_d = W_IDLE;
    endcase
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    if ((wr_state_q == W_AW_W || wr_state_q == W_B) && wr_state_d != W_IDLE &&
        wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      wr_state_d = W_FLUSH;
      wr_done_d  = 1'b1;
      wr_resp_d  = 2'b10;
      wr_to      = 1'b1;
    end
`endif
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rd_data_d  = rd_data_q;
    rd_resp_d  = rd_resp_q;
    rd_valid_d = 1'b0;
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    rcnt_d = rcnt_q + 1'b1;
    rd_to  = 1'b0;
`endif
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req_valid && rd_req_ready) begin
          if ({1'b0, rd_addr[31:30]} >= NB) begin
            rd_valid_d = 1'b1;
            rd_resp_d  = 2'b11;
            rd_data_d  = '0;
          end else begin
            rd_state_d = R_AR;
            arvalid_d  = 1'b1;
            araddr_d   = xlate(rd_addr);
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
            rcnt_d = '0;
`endif
          end
        end
      end
      R_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d  = 1'b0;
          rd_state_d = R_R;
        end
      end
      R_R: begin
        if (M_AXI_RVALID) begin
          rd_state_d = R_IDLE;
          rd_valid_d = 1'b1;
          rd_data_d  = M_AXI_RDATA;
          rd_resp_d  = M_AXI_RRESP;
        end
      end
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
      R_FLUSH: begin
        if (M_AXI_ARREADY) arvalid_d = 1'b0;
        if (M_AXI_RREADY && M_AXI_RVALID) rd_state_d = R_IDLE;
      end
`endif
      default: rd_state_d = R_IDLE;
    endcase
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
    if ((rd_state_q == R_AR || rd_state_q == R_R) && rd_state_d != R_IDLE &&
        rcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      rd_state_d = R_FLUSH;
      rd_valid_d = 1'b1;
      rd_resp_d  = 2'b10;
      rd_data_d  = '0;
      rd_to      = 1'b1;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_data_q  <= '0;
      wr_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_resp_q  <= 2'b00;
      rd_resp_q  <= 2'b00;
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_data_q  <= rd_data_d;
      wr_done_q  <= wr_done_d;
      rd_valid_q <= rd_valid_d;
      wr_resp_q  <= wr_resp_d;
      rd_resp_q  <= rd_resp_d;
`ifdef AXIL_BAR_MASTER_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      to_err_q <= to_err_q | wr_to | rd_to;
`endif
    end
  end
endmodule
